// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: command indices, fixed arguments, error codes and FSM encodings for SD card init
package sd_cmd_pkg;
  localparam logic [5:0] CMD0 = 6'd0, CMD2 = 6'd2, CMD3 = 6'd3, CMD7 = 6'd7, CMD8 = 6'd8;
  localparam logic [5:0] CMD55 = 6'd55, ACMD41 = 6'd41, R3_IDX = 6'd63;
  localparam logic [31:0] CMD8_ARG = 32'h0000_01AA, ACMD41_ARG = 32'h40FF_8000;
  localparam logic [3:0] ERR_NONE = 4'd0, ERR_TIMEOUT = 4'd1, ERR_ECHO = 4'd2, ERR_RSP = 4'd3, ERR_RETRY = 4'd4;
  // command states are listed in issue order so the happy path is simply "next state"
  typedef enum logic [3:0] {
    ST_IDLE, ST_POWERUP, ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD2, ST_CMD3, ST_CMD7, ST_DONE, ST_ERR
  } st_e;
  typedef enum logic [1:0] {PH_SEND, PH_TX, PH_RSP, PH_GAP} ph_e;
  function automatic logic [5:0] cmd_of(st_e s);
    return s == ST_CMD8 ? CMD8 : s == ST_CMD55 ? CMD55 : s == ST_ACMD41 ? ACMD41 :
           s == ST_CMD2 ? CMD2 : s == ST_CMD3 ? CMD3 : s == ST_CMD7 ? CMD7 : CMD0;
  endfunction
endpackage

// File: rtl/sd_rsp_timer.sv
// sd_rsp_timer: clearable down-counter that flags expiry TIMEOUT enabled cycles after clear
module sd_rsp_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic ctrl_clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q;
  logic run_q;
  always_ff @(posedge ctrl_clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= W'(TIMEOUT - 1);
      run_q <= 1'b1;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  assign expired_o = run_q && cnt_q == '0;
endmodule

// File: rtl/sd_init_ctrl.sv
// sd_init_ctrl: SDv2 card initialisation sequencer driving sdio_tx/sdio_rx and the clock divider select
module sd_init_ctrl
  import sd_cmd_pkg::*;
#(
  parameter int POWERUP_CLKS     = 80,
  parameter int RSP_TIMEOUT      = 64,
  parameter int ACMD41_RETRY_MAX = 1000,
  parameter int CMD0_GAP         = 8
) (
  input  logic        ctrl_clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic        o_cmd_en,
  output logic [5:0]  o_cmd,
  output logic [31:0] o_para,
  input  logic        i_cmd_done,
  output logic        o_listen,
  output logic        o_rsp136en,
  input  logic        i_rsp_valid,
  input  logic [5:0]  i_rsp_index,
  input  logic [31:0] i_rsp_arg,
  input  logic        i_rsp_crc_ok,
  output logic        o_clk_mod,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [3:0]  o_err_code,
  output logic [15:0] o_rca,
  output logic        o_sdhc
);
  st_e st_q, st_d;
  ph_e ph_q;
  logic [15:0] cnt_q, retry_q, rca_q;
  logic [5:0] cmd_q;
  logic [31:0] para_q;
  logic [3:0] code_q, code_d;
  logic cmd_en_q, listen_q, rsp136_q, clk_mod_q, busy_q, done_q, err_q, sdhc_q;
  logic tmr_exp, idx_ok, not_ready, unused_ok;
  assign unused_ok = ^i_rsp_arg[15:12];
  sd_rsp_timer #(.TIMEOUT(RSP_TIMEOUT)) u_tmr (
    .ctrl_clk (ctrl_clk),
    .rst_n    (rst_n),
    .clr_i    (ph_q == PH_TX && i_cmd_done && st_q != ST_CMD0),
    .en_i     (ph_q == PH_RSP),
    .expired_o(tmr_exp)
  );
  // response verdict; a valid response always takes precedence over timer expiry
  always_comb begin
    idx_ok = st_q == ST_CMD2 || (i_rsp_index == (st_q == ST_ACMD41 ? R3_IDX : cmd_of(st_q)) &&
             (i_rsp_crc_ok || st_q == ST_ACMD41));
    not_ready = st_q == ST_ACMD41 && !i_rsp_arg[31];
    code_d = !i_rsp_valid ? ERR_TIMEOUT : !idx_ok ? ERR_RSP :
             st_q == ST_CMD8 && i_rsp_arg[11:0] != CMD8_ARG[11:0] ? ERR_ECHO :
             not_ready && retry_q + 16'd1 == 16'(ACMD41_RETRY_MAX) ? ERR_RETRY : ERR_NONE;
    st_d = code_d != ERR_NONE ? ST_ERR : not_ready ? ST_CMD55 : st_e'(st_q + 4'd1);
  end
  always_ff @(posedge ctrl_clk or negedge rst_n)
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      ph_q      <= PH_SEND;
      cnt_q     <= '0;
      retry_q   <= '0;
      cmd_en_q  <= 1'b0;
      cmd_q     <= '0;
      para_q    <= '0;
      listen_q  <= 1'b0;
      rsp136_q  <= 1'b0;
      clk_mod_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      rca_q     <= '0;
      sdhc_q    <= 1'b0;
    end else begin
      cmd_en_q <= 1'b0;
      case (st_q)
        ST_IDLE, ST_DONE, ST_ERR: if (i_start) begin
          st_q      <= ST_POWERUP;
          ph_q      <= PH_SEND;
          cnt_q     <= '0;
          retry_q   <= '0;
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
          code_q    <= ERR_NONE;
          rca_q     <= '0;
          sdhc_q    <= 1'b0;
          clk_mod_q <= 1'b1;
        end
        ST_POWERUP: begin
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == 16'(POWERUP_CLKS - 1)) st_q <= ST_CMD0;
        end
        default: case (ph_q)
          PH_SEND: begin
            cmd_en_q <= 1'b1;
            cmd_q    <= cmd_of(st_q);
            para_q   <= st_q == ST_CMD8 ? CMD8_ARG : st_q == ST_ACMD41 ? ACMD41_ARG :
                        st_q == ST_CMD7 ? {rca_q, 16'h0000} : 32'h0;
            ph_q     <= PH_TX;
          end
          PH_TX: if (i_cmd_done) begin
            ph_q     <= st_q == ST_CMD0 ? PH_GAP : PH_RSP;
            listen_q <= st_q != ST_CMD0;
            rsp136_q <= st_q == ST_CMD2;
            cnt_q    <= '0;
          end
          PH_GAP: begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == 16'(CMD0_GAP - 1)) begin
              st_q <= ST_CMD8;
              ph_q <= PH_SEND;
            end
          end
          PH_RSP: if (i_rsp_valid || tmr_exp) begin
            st_q      <= st_d;
            ph_q      <= PH_SEND;
            listen_q  <= 1'b0;
            rsp136_q  <= 1'b0;
            busy_q    <= st_d != ST_DONE && st_d != ST_ERR;
            done_q    <= st_d == ST_DONE;
            clk_mod_q <= st_d != ST_DONE;
            err_q     <= st_d == ST_ERR;
            code_q    <= code_d;
            if (not_ready && st_d == ST_CMD55) retry_q <= retry_q + 16'd1;
            if (st_d == ST_CMD2) sdhc_q <= i_rsp_arg[30];
            if (st_d == ST_CMD7) rca_q <= i_rsp_arg[31:16];
          end
        endcase
      endcase
    end
  assign o_cmd_en   = cmd_en_q;
  assign o_cmd      = cmd_q;
  assign o_para     = para_q;
  assign o_listen   = listen_q;
  assign o_rsp136en = rsp136_q;
  assign o_clk_mod  = clk_mod_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_err_code = code_q;
  assign o_rca      = rca_q;
  assign o_sdhc     = sdhc_q;
endmodule

// File: doc/sd_init_ctrl.md
Name: sd_init_ctrl

Overview:
- Card-initialisation sequencer directly upstream of sdio_tx; consumes sdio_rx response results.
- Drives command strobe/index/argument into sdio_tx, checks each response, extracts RCA and capacity class.
- Releases the fast clock via sdio_clk_control's clk_mod once the card is selected.
- SDv2+ cards only; no v1/MMC fallback.

Parameters:
- POWERUP_CLKS, 80, ctrl_clk cycles idled before CMD0; must be ≥74.
- RSP_TIMEOUT, 64, ctrl_clk cycles allowed from i_cmd_done to i_rsp_valid.
- ACMD41_RETRY_MAX, 1000, CMD55/ACMD41 pairs allowed before the block gives up.
- CMD0_GAP, 8, ctrl_clk cycles waited after CMD0 completes (CMD0 has no response).

Ports:
- ctrl_clk  in  1  Sole clock; the same ctrl_clk as sdio_tx/sdio_rx.
- rst_n  in  1  Asynchronous, active-low reset.
- i_start  in  1  One-cycle pulse; starts initialisation.
- o_cmd_en  out  1  One-cycle strobe to sdio_tx i_en.
- o_cmd  out  6  To sdio_tx i_cmd.
- o_para  out  32  To sdio_tx i_para.
- i_cmd_done  in  1  sdio_tx finished shifting the last command bit.
- o_listen  out  1  To sdio_rx i_listen.
- o_rsp136en  out  1  To sdio_rx i_rsp136en.
- i_rsp_valid  in  1  sdio_rx response captured (one-cycle pulse).
- i_rsp_index  in  6  Response bits [45:40].
- i_rsp_arg  in  32  Response bits [39:8].
- i_rsp_crc_ok  in  1  CRC7 check result.
- o_clk_mod  out  1  To sdio_clk_control clk_mod. 1 = 400 kHz, 0 = fast clock.
- o_busy  out  1  Sequence in progress.
- o_done  out  1  Initialisation complete. Level signal.
- o_err  out  1  Initialisation failed. Level signal.
- o_err_code  out  4  0 none, 1 timeout, 2 CMD8 echo mismatch, 3 index/CRC mismatch, 4 ACMD41 retries exhausted.
- o_rca  out  16  Relative card address from CMD3.
- o_sdhc  out  1  CCS bit from the ACMD41 response.

Behaviour:
Reset values:
- All outputs 0, except o_clk_mod = 1.
- State IDLE; all counters 0.

Main states:
- IDLE → POWERUP → CMD0 → CMD8 → CMD55 → ACMD41 → CMD2 → CMD3 → CMD7 → DONE; ERR is reachable from any command state.

Start:
- i_start in IDLE: next cycle o_busy = 1, POWERUP counter begins.
- i_start in DONE or ERR: clears o_done, o_err, o_err_code, o_rca, o_sdhc; sets o_clk_mod = 1; enters POWERUP.
- i_start while o_busy = 1 is ignored.

Command sub-phases:
- SEND: o_cmd_en high for exactly 1 cycle. o_cmd/o_para are loaded in the same cycle and held stable until the next SEND.
- WAIT_TX: wait for i_cmd_done.
- WAIT_RSP: o_listen = 1 from the cycle after i_cmd_done until i_rsp_valid or timeout. The timeout counter clears on entry to WAIT_RSP.
- Response handling: i_rsp_valid outside WAIT_RSP is ignored. If i_rsp_valid and timeout expiry fall in the same cycle, valid wins.

Per-command rules:
- CMD0: arg 0; no listen. After i_cmd_done, wait CMD0_GAP cycles, then go to CMD8.
- CMD8: arg 0x000001AA. Require index 8, crc_ok, and arg[11:0] = 0x1AA. Echo mismatch → err 2.
- CMD55: arg 0. Require index 55 and crc_ok.
- ACMD41: o_cmd = 41, arg 0x40FF8000. Require index 63; CRC is ignored.
  - arg[31] = 1: o_sdhc ← arg[30], go to CMD2.
  - arg[31] = 0: increment the retry counter. If the count equals ACMD41_RETRY_MAX → err 4; otherwise go to CMD55.
- CMD2: arg 0, o_rsp136en = 1 during WAIT_RSP. Only i_rsp_valid is required; index and CRC are not checked. o_rsp136en returns to 0 on leaving CMD2.
- CMD3: arg 0. Require index 3 and crc_ok. o_rca ← arg[31:16].
- CMD7: arg {o_rca, 16'h0000}. Require index 7 and crc_ok.
  - On success: o_clk_mod ← 0 and o_done ← 1 in the same cycle; o_busy ← 0; state DONE.

Error handling:
- Any timeout → err 1.
- Any index or CRC mismatch (where checked) → err 3.
- ERR: o_err = 1, o_busy = 0, o_listen = 0, o_clk_mod stays 1. Held until the next i_start.

Reset mid-sequence:
- rst_n low mid-sequence immediately returns all state and outputs to reset values, including an in-flight o_cmd_en.

Decomposition:
- Package sd_cmd_pkg:
  - Command indices (CMD0, 2, 3, 7, 8, 55, 41), R3 index 63.
  - CMD8_ARG, ACMD41_ARG.
  - Error-code constants.
  - Main-state and sub-phase enums.
- Sub-module sd_rsp_timer: clearable down-counter of RSP_TIMEOUT cycles that raises an expired flag. Reused by the later data-block read stage.

Test Plan:
- Responder model answers every command correctly; ACMD41 reports busy 3 times, then arg 0xC0FF8000; CMD3 returns arg 0x12340000 → command order 0, 8, (55, 41)×4, 2, 3, 7. CMD7 o_para = 0x12340000; o_rca = 0x1234, o_sdhc = 1, o_done = 1, o_clk_mod falls in the o_done cycle.
- CMD8 response arg 0x000001AB → o_err = 1, code 2, no further o_cmd_en pulses, o_clk_mod stays 1.
- CMD55 left unanswered → exactly RSP_TIMEOUT cycles after i_cmd_done: o_err = 1, code 1, o_listen = 0.
- ACMD41 always returns arg[31] = 0 with ACMD41_RETRY_MAX = 5 → exactly 5 ACMD41 strobes, then err 4.
- i_rsp_valid in the same cycle as timeout expiry with a correct response → sequence proceeds, no error. Pulsing i_start mid-sequence → no effect.
- Assert rst_n = 0 during CMD2 WAIT_RSP, release, pulse i_start → full sequence repeats from POWERUP, o_rca previously 0 remains 0 until CMD3.
